// File: rtl/preg_wb_arbiter_pkg.sv
// Shared types and constants for the physical-register writeback arbiter.
// The writeback record is reused for both the output stage and the bypass path.
package preg_wb_arbiter_pkg;

    localparam int PREG_NUM    = 64;
    localparam int NUM_WB_REQ  = 4;
    localparam int PREG_ADDR_W = $clog2(PREG_NUM);

    typedef logic [PREG_ADDR_W-1:0] preg_addr_t;
    typedef logic [63:0]            u64;

    typedef struct packed {
        logic       valid;
        preg_addr_t wa;
        u64         wd;
    } preg_wb_t;

    // Round-robin slot visited at a given offset after the base index.
    function automatic int rr_slot(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/preg_wb_arbiter_rr.sv
// Combinational round-robin arbiter: searches ptr+1 .. ptr (wrapping) and
// returns a one-hot grant plus its index. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    import preg_wb_arbiter_pkg::*;

    logic          found_s;
    logic [IW-1:0] slot_s;

    // Priority search starting just after the last winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        slot_s    = '0;
        for (int k = 1; k <= N; k++) begin
            slot_s = IW'(rr_slot(int'(ptr), k, N));
            if (!found_s && req[slot_s]) begin
                grant[slot_s] = 1'b1;
                grant_idx     = slot_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/preg_wb_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto the single preg write port and
// keeps the per-preg ready scoreboard. Define PREG_WB_BYPASS_EN to add bp_* outputs.
module preg_wb_arbiter #(
    parameter int NUM_REQ  = preg_wb_arbiter_pkg::NUM_WB_REQ,
    parameter int PREG_NUM = preg_wb_arbiter_pkg::PREG_NUM,
    parameter int ALLOC_W  = 2,
    localparam int ADDR_W  = $clog2(PREG_NUM)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_wa,
    input  logic [NUM_REQ-1:0][63:0]         req_wd,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [ALLOC_W-1:0]               alloc_valid,
    input  logic [ALLOC_W-1:0][ADDR_W-1:0]   alloc_addr,
    output logic                             preg_valid,
    output logic [ADDR_W-1:0]                preg_wa,
    output logic [63:0]                      preg_wd,
    output logic [PREG_NUM-1:0]              preg_rdy
`ifdef PREG_WB_BYPASS_EN
    ,
    output logic                             bp_valid,
    output logic [ADDR_W-1:0]                bp_wa,
    output logic [63:0]                      bp_wd
`endif
);
    import preg_wb_arbiter_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]  arb_req_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic [IDX_W-1:0]    grant_idx_s;
    logic                any_grant_s;
    logic [IDX_W-1:0]    rr_ptr_r;
    preg_wb_t            win_s;
    preg_wb_t            stage_r;
    logic [PREG_NUM-1:0] rdy_r;
    logic [PREG_NUM-1:0] rdy_nxt_s;
    logic [PREG_NUM-1:0] set_mask_s;
    logic [PREG_NUM-1:0] clr_mask_s;

    // No requester may win while in reset or during a flush cycle.
    always_comb begin
        if (reset && !flush) begin
            arb_req_s = req_valid;
        end else begin
            arb_req_s = '0;
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (arb_req_s),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    assign any_grant_s = |grant_s;
    assign req_ready   = grant_s;

    // Winner record; writes to preg 0 are consumed but never committed.
    always_comb begin
        win_s.wa    = req_wa[grant_idx_s];
        win_s.wd    = req_wd[grant_idx_s];
        win_s.valid = any_grant_s && (req_wa[grant_idx_s] != '0);
    end

    // Round-robin pointer follows the last winner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_r <= IDX_W'(NUM_REQ - 1);
        end else if (any_grant_s) begin
            rr_ptr_r <= grant_idx_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Registered output stage feeding the preg write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_r <= '0;
        end else if (flush) begin
            stage_r <= '0;
        end else if (any_grant_s) begin
            stage_r <= win_s;
        end else begin
            stage_r.valid <= 1'b0;
        end
    end

    // A flush in the presentation cycle kills the in-flight write.
    assign preg_valid = stage_r.valid & ~flush;
    assign preg_wa    = stage_r.wa;
    assign preg_wd    = stage_r.wd;

    // Scoreboard next state: commit sets, allocation clears (clear wins), flush sets all.
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        set_mask_s[stage_r.wa] = stage_r.valid;
        for (int j = 0; j < ALLOC_W; j++) begin
            clr_mask_s[alloc_addr[j]] = clr_mask_s[alloc_addr[j]] |
                                        (alloc_valid[j] && (alloc_addr[j] != '0));
        end
        if (flush) begin
            rdy_nxt_s = '1;
        end else begin
            rdy_nxt_s = (rdy_r | set_mask_s) & ~clr_mask_s;
        end
        rdy_nxt_s[0] = 1'b1;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_r <= '1;
        end else begin
            rdy_r <= rdy_nxt_s;
        end
    end

    assign preg_rdy = rdy_r;

`ifdef PREG_WB_BYPASS_EN
    assign bp_valid = win_s.valid;
    assign bp_wa    = win_s.wa;
    assign bp_wd    = win_s.wd;
`endif

endmodule

// File: tb/tb_preg_wb_arbiter.sv
// Self-checking bench for preg_wb_arbiter: vector table, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_preg_wb_arbiter;

    logic             clk;
    logic             reset;
    logic             flush;
    logic [3:0]       req_valid;
    logic [3:0][5:0]  req_wa;
    logic [3:0][63:0] req_wd;
    logic [3:0]       req_ready;
    logic [1:0]       alloc_valid;
    logic [1:0][5:0]  alloc_addr;
    logic             preg_valid;
    logic [5:0]       preg_wa;
    logic [63:0]      preg_wd;
    logic [63:0]      preg_rdy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_last;
    bit          m_pv;
    int          m_pwa;
    logic [63:0] m_pwd;
    logic [63:0] m_rdy;

    typedef struct {
        logic [3:0] rv;
        logic       fl;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[12];

    preg_wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_wa      (req_wa),
        .req_wd      (req_wd),
        .req_ready   (req_ready),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .preg_valid  (preg_valid),
        .preg_wa     (preg_wa),
        .preg_wd     (preg_wd),
        .preg_rdy    (preg_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 3;
        m_pv   = 1'b0;
        m_pwa  = 0;
        m_pwd  = 64'd0;
        m_rdy  = '1;
    endtask

    function automatic int model_pick();
        if (reset !== 1'b1 || flush) return -1;
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (m_last + k) % 4;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // Compare the current cycle against the model, then advance it past the edge.
    task automatic sample(output int g);
        logic [3:0] exp_r;
        bit         exp_pv;
        #2;
        g      = model_pick();
        exp_r  = 4'b0000;
        if (g >= 0) exp_r[g] = 1'b1;
        exp_pv = m_pv && !flush;
        chk("req_ready", {60'd0, req_ready}, {60'd0, exp_r});
        chk("preg_valid", {63'd0, preg_valid}, {63'd0, exp_pv});
        if (exp_pv) begin
            chk("preg_wa", {58'd0, preg_wa}, 64'(m_pwa));
            chk("preg_wd", preg_wd, m_pwd);
        end
        chk("preg_rdy", preg_rdy, m_rdy);
        if (flush) begin
            m_rdy = '1;
        end else begin
            if (m_pv) m_rdy[m_pwa] = 1'b1;
            for (int j = 0; j < 2; j++)
                if (alloc_valid[j] && alloc_addr[j] != 6'd0) m_rdy[alloc_addr[j]] = 1'b0;
        end
        m_rdy[0] = 1'b1;
        if (g >= 0) begin
            m_pv   = (req_wa[g] != 6'd0);
            m_pwa  = int'(req_wa[g]);
            m_pwd  = req_wd[g];
            m_last = g;
        end else begin
            m_pv = 1'b0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid   = 4'b0000;
        flush       = 1'b0;
        alloc_valid = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int  g;
        bit  hv[4];
        tbl[0]  = '{4'b0001, 1'b0, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b0, 4'b1000};
        tbl[4]  = '{4'b1010, 1'b0, 4'b0010};
        tbl[5]  = '{4'b1010, 1'b0, 4'b1000};
        tbl[6]  = '{4'b0110, 1'b1, 4'b0000};
        tbl[7]  = '{4'b0110, 1'b0, 4'b0010};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000};
        tbl[9]  = '{4'b0011, 1'b0, 4'b0001};
        tbl[10] = '{4'b1001, 1'b0, 4'b1000};
        tbl[11] = '{4'b1111, 1'b0, 4'b0001};

        reset = 1'b1;
        idle_inputs();
        req_wa = '0;
        req_wd = '0;
        alloc_addr = '0;
        #1 reset = 1'b0;
        req_valid = 4'b1111;
        #3;
        chk("rst_ready", {60'd0, req_ready}, 64'd0);
        chk("rst_valid", {63'd0, preg_valid}, 64'd0);
        chk("rst_wa", {58'd0, preg_wa}, 64'd0);
        chk("rst_wd", preg_wd, 64'd0);
        chk("rst_rdy", preg_rdy, '1);
        do_reset();

        // T1: single write, scoreboard rises two cycles after grant
        alloc_valid = 2'b01; alloc_addr[0] = 6'd5;
        sample(g); next_cycle();
        alloc_valid = 2'b00;
        req_valid = 4'b0001; req_wa[0] = 6'd5; req_wd[0] = 64'hAA;
        sample(g);
        chk("t1_ready", {60'd0, req_ready}, 64'h1);
        chk("t1_rdy5_low", {63'd0, preg_rdy[5]}, 64'd0);
        next_cycle();
        req_valid = 4'b0000;
        sample(g);
        chk("t1_valid", {63'd0, preg_valid}, 64'd1);
        chk("t1_wa", {58'd0, preg_wa}, 64'd5);
        chk("t1_wd", preg_wd, 64'hAA);
        chk("t1_rdy5_still_low", {63'd0, preg_rdy[5]}, 64'd0);
        next_cycle();
        sample(g);
        chk("t1_rdy5_high", {63'd0, preg_rdy[5]}, 64'd1);
        next_cycle();

        // T2: all four requesting, fair order and back-to-back writes
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_wa[i] = 6'(10 + i);
            req_wd[i] = 64'(100 + i);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            logic [3:0] e;
            e = 4'b0001 << c;
            sample(g);
            chk("t2_grant", {60'd0, req_ready}, {60'd0, e});
            if (c > 0) chk("t2_no_bubble", {63'd0, preg_valid}, 64'd1);
            next_cycle();
        end
        req_valid = 4'b0000;
        sample(g);
        chk("t2_last_write", {63'd0, preg_valid}, 64'd1);
        next_cycle();

        // T3: alloc then write, then write commit racing a same-edge alloc
        alloc_valid = 2'b01; alloc_addr[0] = 6'd9;
        sample(g); next_cycle();
        alloc_valid = 2'b00;
        req_valid = 4'b0010; req_wa[1] = 6'd9; req_wd[1] = 64'h99;
        sample(g);
        chk("t3_rdy9_cleared", {63'd0, preg_rdy[9]}, 64'd0);
        chk("t3_ready", {60'd0, req_ready}, 64'h2);
        next_cycle();
        req_valid = 4'b0000;
        sample(g);
        chk("t3_rdy9_at_commit", {63'd0, preg_rdy[9]}, 64'd0);
        next_cycle();
        sample(g);
        chk("t3_rdy9_set", {63'd0, preg_rdy[9]}, 64'd1);
        next_cycle();
        alloc_valid = 2'b11; alloc_addr[0] = 6'd9; alloc_addr[1] = 6'd9;
        sample(g); next_cycle();
        alloc_valid = 2'b00;
        req_valid = 4'b0010;
        sample(g); next_cycle();
        req_valid = 4'b0000;
        alloc_valid = 2'b01; alloc_addr[0] = 6'd9;
        sample(g); next_cycle();
        alloc_valid = 2'b00;
        sample(g);
        chk("t3_clear_wins", {63'd0, preg_rdy[9]}, 64'd0);
        next_cycle();

        // T4: flush during the presentation cycle
        alloc_valid = 2'b11; alloc_addr[0] = 6'd7; alloc_addr[1] = 6'd20;
        sample(g); next_cycle();
        alloc_valid = 2'b00;
        req_valid = 4'b0100; req_wa[2] = 6'd7; req_wd[2] = 64'h77;
        sample(g);
        chk("t4_grant", {60'd0, req_ready}, 64'h4);
        next_cycle();
        req_valid = 4'b0011; flush = 1'b1;
        alloc_valid = 2'b01; alloc_addr[0] = 6'd30;
        sample(g);
        chk("t4_flush_no_grant", {60'd0, req_ready}, 64'd0);
        chk("t4_flush_kill", {63'd0, preg_valid}, 64'd0);
        next_cycle();
        idle_inputs();
        sample(g);
        chk("t4_rdy_all", preg_rdy, '1);
        chk("t4_valid_after", {63'd0, preg_valid}, 64'd0);
        next_cycle();

        // T5: write to preg 0 is consumed but never committed
        req_valid = 4'b0001; req_wa[0] = 6'd0; req_wd[0] = 64'h5;
        sample(g);
        chk("t5_ready", {60'd0, req_ready}, 64'h1);
        next_cycle();
        req_valid = 4'b0000;
        sample(g);
        chk("t5_no_write", {63'd0, preg_valid}, 64'd0);
        chk("t5_rdy0", {63'd0, preg_rdy[0]}, 64'd1);
        next_cycle();

        // T6: asynchronous reset with a write in flight
        req_valid = 4'b1000; req_wa[3] = 6'd33; req_wd[3] = 64'h3333;
        sample(g); next_cycle();
        req_valid = 4'b0000;
        sample(g);
        chk("t6_valid_before", {63'd0, preg_valid}, 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("t6_async_drop", {63'd0, preg_valid}, 64'd0);
        req_valid = 4'b1111;
        #1;
        chk("t6_ready_in_reset", {60'd0, req_ready}, 64'd0);
        chk("t6_rdy_in_reset", preg_rdy, '1);
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        sample(g);
        chk("t6_first_after_reset", {60'd0, req_ready}, 64'h1);
        next_cycle();

        // Vector table: arbitration sequence from a fresh pointer
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_wa[i] = 6'(i + 1);
            req_wd[i] = 64'(i + 200);
        end
        for (int v = 0; v < 12; v++) begin
            req_valid = tbl[v].rv;
            flush     = tbl[v].fl;
            sample(g);
            chk("tbl_ready", {60'd0, req_ready}, {60'd0, tbl[v].exp});
            next_cycle();
        end
        idle_inputs();

        // Randomized traffic: requesters hold their write until granted
        for (int i = 0; i < 4; i++) hv[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!hv[i] && ($urandom_range(1, 0) == 1)) begin
                    hv[i]     = 1'b1;
                    req_wa[i] = 6'($urandom_range(7, 0));
                    req_wd[i] = {$urandom, $urandom};
                end
                req_valid[i] = hv[i];
            end
            flush = ($urandom_range(15, 0) == 0);
            for (int j = 0; j < 2; j++) begin
                alloc_valid[j] = ($urandom_range(2, 0) == 0);
                alloc_addr[j]  = 6'($urandom_range(7, 0));
            end
            sample(g);
            if (g >= 0) hv[g] = 1'b0;
            next_cycle();
        end
        idle_inputs();
        sample(g);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
